// File: rtl/decomp_pkg.sv
// decomp_pkg: shared widths and line type for the word-decompression path.
package decomp_pkg;
    localparam int LINE_W          = 128;
    localparam int BEATS_PER_BLOCK = 4;
    typedef logic [LINE_W-1:0] line_t;
endpackage

// File: rtl/line_fifo_mem.sv
// line_fifo_mem: DEPTH x DATA_W register array, one write port, async read.
module line_fifo_mem #(
    parameter  int DATA_W = 128,
    parameter  int DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk)
        if (i_we) r_mem[i_waddr] <= i_wdata;

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/line_out_fifo.sv
// line_out_fifo: buffers packer lines for the cache-fill port, tags block-final beats
// and flags lines dropped while full (the packer cannot be stalled).
module line_out_fifo
    import decomp_pkg::*;
#(
    parameter int DATA_W = LINE_W,
    parameter int DEPTH  = 4,
    parameter int BEATS  = BEATS_PER_BLOCK
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [DATA_W-1:0]          i_line,
    input  logic                       i_count,
    input  logic                       i_clear,
    output logic [DATA_W-1:0]          o_data,
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic                       o_last,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic                       o_full,
    output logic                       o_overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);
    localparam int BW = $clog2(BEATS);

    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic [BW-1:0]     r_beat;
    logic              r_overflow;
    logic [DATA_W-1:0] w_rdata;
    logic              w_valid, w_full, w_pop, w_push, w_drop;

    assign w_valid = r_level != '0;
    assign w_full  = r_level == LW'(DEPTH);
    assign w_pop   = w_valid && i_ready;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push  = i_count && (!w_full || w_pop);
    assign w_drop  = i_count && !w_push;

    line_fifo_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
        .i_clk   (i_clk),
        .i_we    (w_push && !i_clear),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_line),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge i_clk or negedge i_reset)
        if (!i_reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_beat     <= '0;
            r_overflow <= 1'b0;
        end else if (i_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_beat     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
                r_beat   <= r_beat + BW'(1);
            end
            r_level <= r_level + LW'(w_push) - LW'(w_pop);
            if (w_drop) r_overflow <= 1'b1;
        end

    assign o_valid    = w_valid;
    assign o_data     = w_valid ? w_rdata : '0;
    assign o_last     = w_valid && r_beat == BW'(BEATS - 1);
    assign o_level    = r_level;
    assign o_full     = w_full;
    assign o_overflow = r_overflow;
endmodule

// File: tb/tb_line_out_fifo.sv
// tb_line_out_fifo: directed scenarios plus random traffic, checked by a queue-based reference model.
module tb_line_out_fifo;
    import decomp_pkg::*;
    localparam int DEPTH = 4;
    localparam int BEATS = BEATS_PER_BLOCK;

    logic        clk = 1'b0;
    logic        i_reset = 1'b0;
    line_t       i_line = '0;
    logic        i_count = 1'b0, i_clear = 1'b0, i_ready = 1'b0;
    line_t       o_data;
    logic        o_valid, o_last, o_full, o_overflow;
    logic [2:0]  o_level;

    int n_cmp = 0, n_bad = 0;

    line_t sb[$];
    int    beat = 0;
    bit    ovf = 1'b0;
    bit    pop, room;

    line_out_fifo #(.DATA_W(LINE_W), .DEPTH(DEPTH), .BEATS(BEATS)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_line(i_line), .i_count(i_count),
        .i_clear(i_clear), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_last(o_last), .o_level(o_level), .o_full(o_full), .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
        end
    endtask

    // Monitor + reference model: sampled mid-cycle, compares, then advances the model by the coming edge.
    always @(negedge clk) begin
        if (!i_reset) begin
            chk("rst_valid", o_valid, 0);
            chk("rst_data", o_data, 0);
            chk("rst_last", o_last, 0);
            chk("rst_level", o_level, 0);
            chk("rst_full", o_full, 0);
            chk("rst_ovf", o_overflow, 0);
            sb.delete();
            beat = 0;
            ovf = 1'b0;
        end else begin
            chk("valid", o_valid, sb.size() != 0);
            chk("level", o_level, sb.size());
            chk("full", o_full, sb.size() == DEPTH);
            chk("overflow", o_overflow, ovf);
            if (sb.size() != 0) begin
                chk("data", o_data, sb[0]);
                chk("last", o_last, beat == BEATS - 1);
            end else begin
                chk("idle_data", o_data, 0);
                chk("idle_last", o_last, 0);
            end
            if (i_clear) begin
                sb.delete();
                beat = 0;
                ovf = 1'b0;
            end else begin
                pop  = sb.size() != 0 && i_ready;
                room = sb.size() < DEPTH;
                if (pop) begin
                    void'(sb.pop_front());
                    beat = (beat + 1) % BEATS;
                end
                if (i_count) begin
                    if (room || pop) sb.push_back(i_line);
                    else ovf = 1'b1;
                end
            end
        end
    end

    task automatic cyc(input logic cnt, input line_t ln, input logic rdy, input logic clr);
        i_count = cnt;
        i_line  = ln;
        i_ready = rdy;
        i_clear = clr;
        @(posedge clk);
        #1;
    endtask

    function automatic line_t rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        line_t a5;
        a5 = {16{8'hA5}};
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b1;
        // 1: single line, immediate drain
        cyc(1, a5, 1, 0);
        chk("t1_valid", o_valid, 1);
        chk("t1_data", o_data, a5);
        chk("t1_last", o_last, 0);
        repeat (3) cyc(0, '0, 1, 0);
        chk("t1_empty", o_valid, 0);
        // 2: eight lines every other cycle from beat 0
        cyc(0, '0, 1, 1);
        for (int i = 0; i < 8; i++) begin
            cyc(1, rnd_line(), 1, 0);
            cyc(0, '0, 1, 0);
        end
        // 3: fill, overflow, drain
        cyc(0, '0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, rnd_line(), 0, 0);
        chk("t3_full", o_full, 1);
        chk("t3_level", o_level, 4);
        cyc(1, rnd_line(), 0, 0);
        chk("t3_ovf", o_overflow, 1);
        chk("t3_level_hold", o_level, 4);
        repeat (5) cyc(0, '0, 1, 0);
        // 4: push and pop while full
        cyc(0, '0, 0, 1);
        for (int i = 0; i < 4; i++) cyc(1, rnd_line(), 0, 0);
        cyc(1, rnd_line(), 1, 0);
        chk("t4_level", o_level, 4);
        chk("t4_ovf", o_overflow, 0);
        repeat (5) cyc(0, '0, 1, 0);
        // 5: clear beats a concurrent strobe
        cyc(0, '0, 0, 1);
        for (int i = 0; i < 3; i++) cyc(1, rnd_line(), 0, 0);
        cyc(0, '0, 1, 0);
        cyc(1, rnd_line(), 0, 1);
        chk("t5_valid", o_valid, 0);
        chk("t5_level", o_level, 0);
        cyc(1, rnd_line(), 0, 0);
        chk("t5_last", o_last, 0);
        repeat (3) cyc(0, '0, 1, 0);
        // 6: async reset mid-block
        cyc(0, '0, 1, 0);
        cyc(0, '0, 1, 0);
        for (int i = 0; i < 3; i++) cyc(1, rnd_line(), 0, 0);
        #2;
        i_reset = 1'b0;
        #1;
        chk("t6_valid", o_valid, 0);
        chk("t6_data", o_data, 0);
        chk("t6_level", o_level, 0);
        @(posedge clk);
        #1;
        i_reset = 1'b1;
        cyc(1, rnd_line(), 0, 0);
        chk("t6_last", o_last, 0);
        // random traffic
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom_range(0, 1)), rnd_line(), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 40) == 0));
        repeat (6) cyc(0, '0, 1, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
